// File: rtl/ycr_reset_seq_pkg.sv
// Shared types for the core reset sequencer.
//   seq_state_e : sequencer state encoding
//   CAUSE_*     : bit positions inside the sticky reset-cause register
package ycr_reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_DBG = 2;
  localparam int CAUSE_WDT = 3;

endpackage

// File: rtl/ycr_reset_seq_ctrl.sv
// Reset sequencer for the core subsystem.
// Any reset source puts every domain into reset together. The domains are
// held for ASSERT_CYC cycles after the last request, then released one at a
// time, lowest index first. Each release waits at least STEP_CYC cycles and
// for that domain's readiness gate.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ASSERT  | all domains in reset, counting the hold time
// RELEASE | releasing domain idx once the gap has elapsed and the gate is open
// DONE    | single cycle after the last release, seq_done pulses
// RUN     | idle, all domains out of reset
//
// Ports:
//   clk, rst     : core clock, synchronous active-high reset (power-on cause)
//   test_mode    : 1 = every dom_rst_n follows test_rst_n
//   test_rst_n   : test reset, active-low
//   sw/dbg/wdt_rst_req : level reset requests
//   rel_gate     : per-domain release permission
//   cause_clr    : clears rst_cause (a request in the same cycle still sets its bit)
//   dom_rst_n    : active-low domain resets
//   seq_busy     : high unless in RUN
//   seq_done     : one-cycle pulse at the end of a sequence
//   rst_cause    : sticky {wdt, dbg, sw, por}
module ycr_reset_seq_ctrl
  import ycr_reset_seq_pkg::*;
#(
  parameter int N_DOM      = 4,
  parameter int ASSERT_CYC = 8,
  parameter int STEP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_mode,
  input  logic             test_rst_n,
  input  logic             sw_rst_req,
  input  logic             dbg_rst_req,
  input  logic             wdt_rst_req,
  input  logic [N_DOM-1:0] rel_gate,
  input  logic             cause_clr,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             seq_busy,
  output logic             seq_done,
  output logic [3:0]       rst_cause
);

  localparam int MAX_CYC = (ASSERT_CYC > STEP_CYC) ? ASSERT_CYC : STEP_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int IW      = $clog2(N_DOM);

  localparam logic [CW-1:0] ASSERT_LAST = CW'(ASSERT_CYC - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_DOM - 1);

  seq_state_e       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [N_DOM-1:0] dom_q;
  logic [3:0]       cause_q;
  logic [3:0]       cause_d;
  logic             req;

  assign req = sw_rst_req | dbg_rst_req | wdt_rst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ASSERT;
      cnt   <= '0;
      idx   <= '0;
      dom_q <= '0;
    end else begin
      case (state)
        ASSERT: begin
          dom_q <= '0;
          // Any request restarts the hold, so it always measures from the
          // last cycle a request was seen.
          if (req) begin
            cnt <= '0;
          end else if (cnt == ASSERT_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (req) begin
            state <= ASSERT;
            cnt   <= '0;
            idx   <= '0;
            dom_q <= '0;
          end else if (cnt == STEP_LAST && rel_gate[idx]) begin
            dom_q[idx] <= 1'b1;
            cnt        <= '0;
            if (idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (cnt != STEP_LAST) begin
            // Saturate while the gate is closed so release follows
            // the gate opening by a single cycle.
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (req) begin
            state <= ASSERT;
            cnt   <= '0;
            idx   <= '0;
            dom_q <= '0;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (req) begin
            state <= ASSERT;
            cnt   <= '0;
            idx   <= '0;
            dom_q <= '0;
          end else begin
            dom_q <= '1;
          end
        end

        default: begin
          state <= ASSERT;
          cnt   <= '0;
          idx   <= '0;
          dom_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    cause_d            = cause_clr ? 4'b0000 : cause_q;
    cause_d[CAUSE_SW]  = cause_d[CAUSE_SW]  | sw_rst_req;
    cause_d[CAUSE_DBG] = cause_d[CAUSE_DBG] | dbg_rst_req;
    cause_d[CAUSE_WDT] = cause_d[CAUSE_WDT] | wdt_rst_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= 4'b0001;
    end else begin
      cause_q <= cause_d;
    end
  end

  // Only the test bypass mux sits between the flops and the domain resets.
  assign dom_rst_n = test_mode ? {N_DOM{test_rst_n}} : dom_q;
  assign seq_busy  = (state != RUN);
  assign seq_done  = (state == DONE);
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_ycr_reset_seq_ctrl.sv
module tb_ycr_reset_seq_ctrl;

  localparam int N_DOM      = 4;
  localparam int ASSERT_CYC = 8;
  localparam int STEP_CYC   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             test_mode = 1'b0;
  logic             test_rst_n = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic             dbg_rst_req = 1'b0;
  logic             wdt_rst_req = 1'b0;
  logic [N_DOM-1:0] rel_gate = '1;
  logic             cause_clr = 1'b0;
  logic [N_DOM-1:0] dom_rst_n;
  logic             seq_busy;
  logic             seq_done;
  logic [3:0]       rst_cause;

  ycr_reset_seq_ctrl #(
    .N_DOM(N_DOM), .ASSERT_CYC(ASSERT_CYC), .STEP_CYC(STEP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .test_mode(test_mode), .test_rst_n(test_rst_n),
    .sw_rst_req(sw_rst_req), .dbg_rst_req(dbg_rst_req), .wdt_rst_req(wdt_rst_req),
    .rel_gate(rel_gate), .cause_clr(cause_clr), .dom_rst_n(dom_rst_n),
    .seq_busy(seq_busy), .seq_done(seq_done), .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: hold timer, number of released domains, time in current step.
  bit       m_hold;
  int       m_hold_age;
  int       m_rel;
  int       m_age;
  bit       m_done;
  bit       m_run;
  logic [3:0] m_cause;

  int rise [N_DOM];
  int done_at;
  int idle_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b1; m_hold_age = 0; m_rel = 0; m_age = 0;
    m_done = 1'b0; m_run = 1'b0; m_cause = 4'b0001;
  endtask

  task automatic model_update();
    bit r;
    r = sw_rst_req | dbg_rst_req | wdt_rst_req;
    if (rst) begin
      model_reset();
      return;
    end
    if (cause_clr) m_cause = 4'b0000;
    m_cause = m_cause | {wdt_rst_req, dbg_rst_req, sw_rst_req, 1'b0};
    if (r && !m_hold) begin
      m_hold = 1'b1; m_hold_age = 0; m_rel = 0; m_age = 0;
      m_done = 1'b0; m_run = 1'b0;
    end else if (m_hold) begin
      if (r) m_hold_age = 0;
      else if (m_hold_age >= ASSERT_CYC - 1) begin m_hold = 1'b0; m_age = 0; end
      else m_hold_age++;
    end else if (m_rel < N_DOM) begin
      if (m_age >= STEP_CYC - 1 && rel_gate[m_rel]) begin
        m_rel++;
        m_age = 0;
        if (m_rel == N_DOM) m_done = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_run  = 1'b1;
    end
  endtask

  task automatic clear_marks();
    for (int i = 0; i < N_DOM; i++) rise[i] = -1;
    done_at = -1;
    idle_at = -1;
  endtask

  // One clock cycle: compare outputs mid-cycle, advance model, move past the edge.
  task automatic step();
    logic [N_DOM-1:0] exp_dom;
    @(negedge clk);
    exp_dom = test_mode ? {N_DOM{test_rst_n}} : N_DOM'((1 << m_rel) - 1);
    check("dom_rst_n", 32'(dom_rst_n), 32'(exp_dom));
    check("seq_busy", 32'(seq_busy), 32'(!m_run));
    check("seq_done", 32'(seq_done), 32'(m_done));
    check("rst_cause", 32'(rst_cause), 32'(m_cause));
    for (int i = 0; i < N_DOM; i++)
      if (!test_mode && dom_rst_n[i] === 1'b1 && rise[i] < 0) rise[i] = cyc;
    if (seq_done === 1'b1 && done_at < 0) done_at = cyc;
    if (seq_busy === 1'b0 && idle_at < 0) idle_at = cyc;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
    clear_marks();
  endtask

  initial begin
    // 1: power-on
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
    clear_marks();
    check("reset_dom", 32'(dom_rst_n), 32'(0));
    check("reset_busy", 32'(seq_busy), 32'(1));
    check("reset_done", 32'(seq_done), 32'(0));
    check("reset_cause", 32'(rst_cause), 32'(4'b0001));
    run_to(40);
    for (int i = 0; i < N_DOM; i++)
      check("por_rise", 32'(rise[i]), 32'(ASSERT_CYC + (i + 1) * STEP_CYC));
    check("por_done_at", 32'(done_at), 32'(24));
    check("por_idle_at", 32'(idle_at), 32'(25));
    check("por_cause", 32'(rst_cause), 32'(4'b0001));

    // 2: gate stall on domain 1
    do_reset();
    rel_gate = 4'b1101;
    run_to(30);
    rel_gate = 4'b1111;
    run_to(45);
    check("stall_rise0", 32'(rise[0]), 32'(12));
    check("stall_rise1", 32'(rise[1]), 32'(31));
    check("stall_rise2", 32'(rise[2]), 32'(35));
    check("stall_rise3", 32'(rise[3]), 32'(39));
    check("stall_done_at", 32'(done_at), 32'(39));

    // 3: watchdog pulse mid-release
    do_reset();
    run_to(18);
    wdt_rst_req = 1'b1;
    step();
    wdt_rst_req = 1'b0;
    check("wdt_dom_low", 32'(dom_rst_n), 32'(0));
    clear_marks();
    run_to(50);
    check("wdt_rise0", 32'(rise[0]), 32'(31));
    check("wdt_rise1", 32'(rise[1]), 32'(35));
    check("wdt_rise2", 32'(rise[2]), 32'(39));
    check("wdt_rise3", 32'(rise[3]), 32'(43));
    check("wdt_cause", 32'(rst_cause), 32'(4'b1001));

    // 4: software request held 5 cycles from RUN; hold runs from cycle 55
    sw_rst_req = 1'b1;
    repeat (5) step();
    sw_rst_req = 1'b0;
    clear_marks();
    run_to(75);
    check("hold_rise0", 32'(rise[0]), 32'(55 + ASSERT_CYC + STEP_CYC));
    check("hold_cause_sw", 32'(rst_cause[1]), 32'(1));

    // 5: clear against set
    cause_clr = 1'b1;
    dbg_rst_req = 1'b1;
    step();
    cause_clr = 1'b0;
    dbg_rst_req = 1'b0;
    check("clr_vs_dbg", 32'(rst_cause), 32'(4'b0100));
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    check("clr_only", 32'(rst_cause), 32'(4'b0000));

    // 6: test bypass during ASSERT
    do_reset();
    run_to(2);
    test_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      test_rst_n = k[0];
      #1;
      check("bypass_follow", 32'(dom_rst_n), 32'({N_DOM{test_rst_n}}));
      step();
    end
    test_mode = 1'b0;
    test_rst_n = 1'b0;
    run_to(30);
    check("bypass_rise0", 32'(rise[0]), 32'(12));
    check("bypass_done_at", 32'(done_at), 32'(24));

    // 7: randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      sw_rst_req  = ($urandom_range(0, 59) == 0);
      dbg_rst_req = ($urandom_range(0, 79) == 0);
      wdt_rst_req = ($urandom_range(0, 99) == 0);
      cause_clr   = ($urandom_range(0, 29) == 0);
      for (int b = 0; b < N_DOM; b++) rel_gate[b] = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 39) == 0) test_mode = ~test_mode;
      test_rst_n  = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
